// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives PC and IFID/IDEX/EXMEM/MEMWB latch enables and flushes.
// Optional macro PIPE_PERF_EN adds the stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned DWAIT_MAX = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        exmem_dREN,
   input  logic        exmem_dWEN,
   input  logic        exmem_halt,
   input  logic        branch_taken,
   input  logic        idex_dREN,
   input  logic [4:0]  idex_wsel,
   input  logic [4:0]  ifid_rs,
   input  logic [4:0]  ifid_rt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        memwb_flush,
   output logic        halt_o,
   output logic        dwait_err,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   // Which hazard rule won this cycle, in descending priority.
   typedef enum logic [2:0] {
      R_HALTED, R_HALT, R_DMISS, R_DHIT, R_BRANCH, R_LOAD_USE, R_IMISS, R_FLOW
   } rule_t;

   typedef struct packed {
      logic pc;
      logic ifid_e;
      logic idex_e;
      logic exmem_e;
      logic memwb_e;
      logic ifid_f;
      logic idex_f;
      logic exmem_f;
      logic memwb_f;
      logic halt;
   } ctl_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(DWAIT_MAX);

   state_t     state;
   rule_t      rule;
   ctl_t       ctl;
   logic [7:0] wait_cnt;
   logic [7:0] wait_inc;
   logic       mreq;
   logic       load_use;

   assign mreq     = exmem_dREN | exmem_dWEN;
   assign load_use = idex_dREN && (idex_wsel != 5'd0) &&
                     ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
   assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

   // With mreq low, adv reduces to ihit, so the branch rule only needs ihit.
   always_comb begin
      // NOTE: default first so every path assigns rule and no latch is inferred.
      rule = R_FLOW;
      if (state == HALTED)                          rule = R_HALTED;
      else if (state == RUN && exmem_halt && !mreq) rule = R_HALT;
      else if (mreq && !dhit)                       rule = R_DMISS;
      else if (mreq)                                rule = R_DHIT;
      else if (branch_taken && ihit)                rule = R_BRANCH;
      else if (load_use)                            rule = R_LOAD_USE;
      else if (!ihit)                               rule = R_IMISS;
   end

   always_comb begin
      ctl = '0;
      case (rule)
         R_HALTED:   ctl = '{halt: 1'b1, default: 1'b0};
         R_HALT:     ctl = '{pc: 1'b0, memwb_f: 1'b0, halt: 1'b0, default: 1'b1};
         R_DMISS:    ctl = '{memwb_e: 1'b1, memwb_f: 1'b1, default: 1'b0};
         R_DHIT:     ctl = '{pc: ihit, ifid_e: 1'b1, idex_e: 1'b1, exmem_e: 1'b1,
                             memwb_e: 1'b1, ifid_f: !ihit, default: 1'b0};
         R_BRANCH:   ctl = '{memwb_f: 1'b0, halt: 1'b0, default: 1'b1};
         R_LOAD_USE: ctl = '{idex_e: 1'b1, exmem_e: 1'b1, memwb_e: 1'b1,
                             idex_f: 1'b1, default: 1'b0};
         R_IMISS:    ctl = '{ifid_e: 1'b1, idex_e: 1'b1, exmem_e: 1'b1, memwb_e: 1'b1,
                             ifid_f: 1'b1, default: 1'b0};
         default:    ctl = '{pc: 1'b1, ifid_e: 1'b1, idex_e: 1'b1, exmem_e: 1'b1,
                             memwb_e: 1'b1, default: 1'b0};
      endcase
      // Latches must hold still while reset is asserted, regardless of inputs.
      if (!nRST) ctl = '0;
   end

   assign pc_en       = ctl.pc;
   assign ifid_en     = ctl.ifid_e;
   assign idex_en     = ctl.idex_e;
   assign exmem_en    = ctl.exmem_e;
   assign memwb_en    = ctl.memwb_e;
   assign ifid_flush  = ctl.ifid_f;
   assign idex_flush  = ctl.idex_f;
   assign exmem_flush = ctl.exmem_f;
   assign memwb_flush = ctl.memwb_f;
   assign halt_o      = ctl.halt;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         wait_cnt  <= '0;
         dwait_err <= 1'b0;
      end else begin
         case (rule)
            R_HALTED: ;
            R_HALT: begin
               state    <= HALTED;
               wait_cnt <= '0;
            end
            R_DMISS: begin
               state    <= DWAIT;
               wait_cnt <= wait_inc;
               if (wait_inc == WAIT_LIMIT) dwait_err <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!ctl.pc && state != HALTED) stall_q <= stall_q + 32'd1;
         if (rule == R_BRANCH)           flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = 32'h0;
   assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed corner sequences
// and a randomized run against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int WMAX = 4;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, branch_taken, idex_dREN;
   logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o, dwait_err;
   logic [31:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit m_halted, m_running, m_err;
   int m_waits;

   typedef struct {
      string      name;
      logic [6:0] ctl;   // ihit dhit dREN dWEN halt branch idex_dREN
      logic [4:0] wsel, rs, rt;
      logic [9:0] exp;   // pc en(ifid idex exmem memwb) flush(ifid idex exmem memwb) halt
   } vec_t;

   vec_t vecs[$];

   pipeline_hazard_ctrl #(.DWAIT_MAX(WMAX)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
      .branch_taken(branch_taken), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .halt_o(halt_o), .dwait_err(dwait_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   function automatic logic [9:0] outs();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b want=%b", name, got, exp);
      end
   endtask

   task automatic drive(input logic [6:0] c, input logic [4:0] w, input logic [4:0] s,
                        input logic [4:0] t);
      {ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, branch_taken, idex_dREN} = c;
      idex_wsel = w;
      ifid_rs   = s;
      ifid_rt   = t;
   endtask

   task automatic add(input string n, input logic [6:0] c, input logic [4:0] w,
                      input logic [4:0] s, input logic [4:0] t, input logic [9:0] e);
      vec_t v;
      v.name = n; v.ctl = c; v.wsel = w; v.rs = s; v.rt = t; v.exp = e;
      vecs.push_back(v);
   endtask

   // Output pattern from the priority rules, given the model state and current inputs.
   function automatic logic [9:0] model_out();
      bit mreq, lu;
      mreq = exmem_dREN || exmem_dWEN;
      lu   = idex_dREN && idex_wsel != 0 && (idex_wsel == ifid_rs || idex_wsel == ifid_rt);
      if (m_halted)                              return 10'b0_0000_0000_1;
      if (m_running && exmem_halt && !mreq)      return 10'b0_1111_1110_0;
      if (mreq && !dhit)                         return 10'b0_0001_0001_0;
      if (mreq)                                  return {ihit, 4'b1111, !ihit, 3'b000, 1'b0};
      if (branch_taken && ihit)                  return 10'b1_1111_1110_0;
      if (lu)                                    return 10'b0_0111_0100_0;
      if (!ihit)                                 return 10'b0_1111_1000_0;
      return 10'b1_1111_0000_0;
   endfunction

   function automatic void model_step();
      bit mreq;
      mreq = exmem_dREN || exmem_dWEN;
      if (m_halted) return;
      if (m_running && exmem_halt && !mreq) m_halted = 1'b1;
      else if (mreq && !dhit) begin
         m_running = 1'b0;
         if (m_waits < 255) m_waits++;
         if (m_waits == WMAX) m_err = 1'b1;
      end else begin
         m_running = 1'b1;
         m_waits   = 0;
      end
   endfunction

   // Async reset pulse placed just after a falling edge, away from the active edge.
   task automatic pulse_reset();
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      check("reset_outs", 32'(outs()), 32'h0);
      check("reset_err", 32'(dwait_err), 32'h0);
      nRST = 1'b1;
      m_halted = 0; m_running = 1; m_err = 0; m_waits = 0;
   endtask

   initial begin
      drive(7'b0, 5'd0, 5'd0, 5'd0);

      //    name             ihit dhit rd wr hlt br ld   wsel   rs     rt     expected
      add("flow",          7'b1_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b1_1111_0000_0);
      add("imiss",         7'b0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b0_1111_1000_0);
      add("lu_rs",         7'b1_0_0_0_0_0_1, 5'd7, 5'd7, 5'd3, 10'b0_0111_0100_0);
      add("lu_rt",         7'b1_0_0_0_0_0_1, 5'd5, 5'd1, 5'd5, 10'b0_0111_0100_0);
      add("lu_r0",         7'b1_0_0_0_0_0_1, 5'd0, 5'd0, 5'd0, 10'b1_1111_0000_0);
      add("lu_noload",     7'b1_0_0_0_0_0_0, 5'd5, 5'd5, 5'd5, 10'b1_1111_0000_0);
      add("lu_imiss",      7'b0_0_0_0_0_0_1, 5'd5, 5'd5, 5'd2, 10'b0_0111_0100_0);
      add("branch",        7'b1_0_0_0_0_1_0, 5'd0, 5'd0, 5'd0, 10'b1_1111_1110_0);
      add("branch_lu",     7'b1_0_0_0_0_1_1, 5'd5, 5'd2, 5'd5, 10'b1_1111_1110_0);
      add("branch_noihit", 7'b0_0_0_0_0_1_0, 5'd0, 5'd0, 5'd0, 10'b0_1111_1000_0);
      add("load_miss",     7'b1_0_1_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b0_0001_0001_0);
      add("store_miss",    7'b1_0_0_1_0_1_1, 5'd5, 5'd5, 5'd5, 10'b0_0001_0001_0);
      add("dhit_ihit",     7'b1_1_1_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b1_1111_0000_0);
      add("dhit_noihit",   7'b0_1_0_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b0_1111_1000_0);
      add("dhit_branch",   7'b1_1_1_0_0_1_0, 5'd0, 5'd0, 5'd0, 10'b1_1111_0000_0);
      add("halt",          7'b1_0_0_0_1_0_0, 5'd0, 5'd0, 5'd0, 10'b0_1111_1110_0);
      add("halt_mreq",     7'b1_0_1_0_1_0_0, 5'd0, 5'd0, 5'd0, 10'b0_0001_0001_0);

      foreach (vecs[i]) begin
         pulse_reset();
         drive(vecs[i].ctl, vecs[i].wsel, vecs[i].rs, vecs[i].rt);
         #1;
         check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      end

      // Reset in the middle of a long data wait, then state must be RUN (halt honoured).
      pulse_reset();
      drive(7'b1_0_1_0_0_0_0, 5'd0, 5'd0, 5'd0);
      repeat (10) @(negedge CLK);
      nRST = 1'b0;
      drive(7'b1_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0);
      #1;
      check("rst_mid_dwait_outs", 32'(outs()), 32'h0);
      check("rst_mid_dwait_err", 32'(dwait_err), 32'h0);
      nRST = 1'b1;
      #1;
      check("rst_release_flow", 32'(outs()), 32'(10'b1_1111_0000_0));
      exmem_halt = 1'b1;
      #1;
      check("rst_release_run", 32'(outs()), 32'(10'b0_1111_1110_0));

      // Three-cycle data miss, then completion with an icache miss.
      pulse_reset();
      drive(7'b1_0_1_0_0_0_0, 5'd0, 5'd0, 5'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("dmiss_c%0d", c), 32'(outs()), 32'(10'b0_0001_0001_0));
         @(negedge CLK);
      end
      drive(7'b0_1_1_0_0_0_0, 5'd0, 5'd0, 5'd0);
      #1;
      check("dmiss_done", 32'(outs()), 32'(10'b0_1111_1000_0));

      // Halt, then stuck halted despite toggling inputs.
      pulse_reset();
      drive(7'b1_0_0_0_1_0_0, 5'd0, 5'd0, 5'd0);
      #1;
      check("halt_enter", 32'(outs()), 32'(10'b0_1111_1110_0));
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         drive(7'(c[0] ? 7'b1_1_0_0_0_1_0 : 7'b0_0_1_0_0_0_0), 5'd0, 5'd0, 5'd0);
         #1;
         check($sformatf("halted_c%0d", c), 32'(outs()), 32'(10'b0_0000_0000_1));
      end

      // Watchdog: sets on the 4th wait edge and stays set after the access completes.
      pulse_reset();
      drive(7'b1_0_0_1_0_0_0, 5'd0, 5'd0, 5'd0);
      for (int e = 1; e <= WMAX; e++) begin
         @(negedge CLK);
         #1;
         check($sformatf("wdog_edge%0d", e), 32'(dwait_err), 32'(e >= WMAX));
      end
      check("wdog_still_stalled", 32'(outs()), 32'(10'b0_0001_0001_0));
      dhit = 1'b1;
      @(negedge CLK);
      #1;
      check("wdog_sticky", 32'(dwait_err), 32'h1);

      // Randomized run against the reference model.
      pulse_reset();
      for (int n = 0; n < 3000; n++) begin
         if (($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0)) begin
            pulse_reset();
         end else begin
            @(negedge CLK);
         end
         ihit         = ($urandom_range(0, 3) != 0);
         dhit         = ($urandom_range(0, 2) == 0);
         exmem_dREN   = ($urandom_range(0, 4) == 0);
         exmem_dWEN   = ($urandom_range(0, 6) == 0);
         exmem_halt   = ($urandom_range(0, 59) == 0);
         branch_taken = ($urandom_range(0, 4) == 0);
         idex_dREN    = ($urandom_range(0, 1) == 0);
         idex_wsel    = 5'($urandom_range(0, 3));
         ifid_rs      = 5'($urandom_range(0, 3));
         ifid_rt      = 5'($urandom_range(0, 3));
         #1;
         check($sformatf("rand%0d_outs", n), 32'(outs()), 32'(model_out()));
         check($sformatf("rand%0d_err", n), 32'(dwait_err), 32'(m_err));
         model_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
